// File: rtl/lrck_period_meter_pkg.sv
// Shared definitions for the LRCK period meter: FSM state encoding and a
// constant-evaluable clog2 used to size the edge counter.
package lrck_period_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 0;
        rem = value - 1;
        while (rem > 0) begin
            res = res + 1;
            rem = rem >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/lrck_period_meter_if.sv
// Control/status bundle between the rate-detect consumer and the period meter.
interface lrck_period_meter_if #(parameter int WIDTH = 16);
    logic             ref_i;
    logic             en_i;
    logic             start_i;
    logic             cont_i;
    logic             busy_o;
    logic             valid_o;
    logic             timeout_o;
    logic [WIDTH-1:0] dat_o;

    modport master (output ref_i, en_i, start_i, cont_i,
                    input  busy_o, valid_o, timeout_o, dat_o);
    modport slave  (input  ref_i, en_i, start_i, cont_i,
                    output busy_o, valid_o, timeout_o, dat_o);
endinterface

// File: rtl/lrck_period_meter_ref_sync_edge.sv
// Brings an asynchronous audio clock into clk_i and flags its rising edges;
// the pulse is seen by downstream logic at the 3rd clk_i edge after the rise.
module lrck_period_meter_ref_sync_edge (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic ref_i,
    output logic redge_o
);
    logic meta_r;
    logic sync_r;
    logic dly_r;

    // Two-stage synchronizer followed by a delay flop for edge detection
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            dly_r  <= 1'b0;
        end else begin
            meta_r <= ref_i;
            sync_r <= meta_r;
            dly_r  <= sync_r;
        end
    end

    assign redge_o = sync_r & ~dly_r;
endmodule

// File: rtl/lrck_period_meter.sv
// Measures how many clk_i cycles span EDGES periods of an asynchronous LRCK,
// reporting a valid result or a saturation timeout.
module lrck_period_meter
    import lrck_period_meter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int EDGES = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    lrck_period_meter_if.slave   bus
);
    localparam int EW = clog2(EDGES + 1);
    localparam logic [WIDTH-1:0] CNT_ZERO  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_MAX   = {WIDTH{1'b1}};
    localparam logic [EW-1:0]    ECNT_ZERO = {EW{1'b0}};
    localparam logic [EW-1:0]    ECNT_ONE  = EW'(1);
    localparam logic [EW-1:0]    ECNT_LAST = EW'(EDGES - 1);

    state_t           state_r, state_nx;
    logic [WIDTH-1:0] cnt_r, cnt_nx;
    logic [WIDTH-1:0] dat_r, dat_nx;
    logic [EW-1:0]    ecnt_r, ecnt_nx;
    logic             valid_r, valid_nx;
    logic             timeout_r, timeout_nx;
    logic             busy_r;
    logic             redge_s;
    logic             sat_s;
    logic [WIDTH-1:0] cnt_inc_s;

    lrck_period_meter_ref_sync_edge u_ref_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .ref_i   (bus.ref_i),
        .redge_o (redge_s)
    );

    // The counter never wraps: once saturated it holds until the FSM acts
    assign sat_s     = (cnt_r == CNT_MAX);
    assign cnt_inc_s = sat_s ? cnt_r : (cnt_r + CNT_ONE);

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state, counter and result decode; a ref edge beats saturation
    always_comb begin
        state_nx   = state_r;
        cnt_nx     = cnt_r;
        ecnt_nx    = ecnt_r;
        dat_nx     = dat_r;
        valid_nx   = 1'b0;
        timeout_nx = 1'b0;
        if (!bus.en_i) begin
            state_nx = ST_IDLE;
            cnt_nx   = CNT_ZERO;
            ecnt_nx  = ECNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        state_nx = ST_ARM;
                        cnt_nx   = CNT_ZERO;
                        ecnt_nx  = ECNT_ZERO;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
                ST_ARM: begin
                    if (redge_s) begin
                        state_nx = ST_MEAS;
                        cnt_nx   = CNT_ZERO;
                        ecnt_nx  = ECNT_ZERO;
                    end else if (sat_s) begin
                        state_nx   = bus.cont_i ? ST_ARM : ST_IDLE;
                        dat_nx     = CNT_MAX;
                        timeout_nx = 1'b1;
                        cnt_nx     = CNT_ZERO;
                    end else begin
                        cnt_nx = cnt_inc_s;
                    end
                end
                ST_MEAS: begin
                    if (redge_s) begin
                        if (ecnt_r == ECNT_LAST) begin
                            // Closing edge doubles as the arming edge in continuous mode
                            state_nx = bus.cont_i ? ST_MEAS : ST_IDLE;
                            dat_nx   = sat_s ? CNT_MAX : (cnt_r + CNT_ONE);
                            valid_nx = 1'b1;
                            cnt_nx   = CNT_ZERO;
                            ecnt_nx  = ECNT_ZERO;
                        end else begin
                            ecnt_nx = ecnt_r + ECNT_ONE;
                            cnt_nx  = cnt_inc_s;
                        end
                    end else if (sat_s) begin
                        state_nx   = bus.cont_i ? ST_ARM : ST_IDLE;
                        dat_nx     = CNT_MAX;
                        timeout_nx = 1'b1;
                        cnt_nx     = CNT_ZERO;
                        ecnt_nx    = ECNT_ZERO;
                    end else begin
                        cnt_nx = cnt_inc_s;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                    cnt_nx   = CNT_ZERO;
                    ecnt_nx  = ECNT_ZERO;
                end
            endcase
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_r     <= CNT_ZERO;
            ecnt_r    <= ECNT_ZERO;
            dat_r     <= CNT_ZERO;
            valid_r   <= 1'b0;
            timeout_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            cnt_r     <= cnt_nx;
            ecnt_r    <= ecnt_nx;
            dat_r     <= dat_nx;
            valid_r   <= valid_nx;
            timeout_r <= timeout_nx;
            busy_r    <= (state_nx != ST_IDLE);
        end
    end

    assign bus.busy_o    = busy_r;
    assign bus.valid_o   = valid_r;
    assign bus.timeout_o = timeout_r;
    assign bus.dat_o     = dat_r;
endmodule

// File: tb/tb_lrck_period_meter.sv
// Directed bench for lrck_period_meter: a 16-bit and an 8-bit instance run
// side by side, driven from a vector table plus hand-written corner sequences.
module tb_lrck_period_meter;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lrck_period_meter_if #(.WIDTH(16)) bus16 ();
    lrck_period_meter_if #(.WIDTH(8))  bus8 ();

    lrck_period_meter #(.WIDTH(16), .EDGES(8)) dut16 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus16)
    );

    lrck_period_meter #(.WIDTH(8), .EDGES(8)) dut8 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus8)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference clock generators: period in clk cycles, 0 holds ref low
    int per16 = 0;
    int per8  = 0;
    int ph16  = 0;
    int ph8   = 0;
    always @(negedge clk) begin
        if (per16 == 0) begin
            bus16.ref_i <= 1'b0;
            ph16        <= 0;
        end else begin
            bus16.ref_i <= (ph16 < per16 / 2);
            ph16        <= (ph16 + 1) % per16;
        end
        if (per8 == 0) begin
            bus8.ref_i <= 1'b0;
            ph8        <= 0;
        end else begin
            bus8.ref_i <= (ph8 < per8 / 2);
            ph8        <= (ph8 + 1) % per8;
        end
    end

    // Event recorder, sampled just after each active edge
    int v16_n = 0, t16_n = 0, v8_n = 0, t8_n = 0;
    int t16_dat = 0, t8_dat = 0, t8_cyc = 0, v8_dat = 0;
    int vq_cyc[$];
    int vq_dat[$];
    int vq_busy[$];
    initial forever begin
        @(posedge clk);
        #1;
        if (bus16.valid_o) begin
            v16_n = v16_n + 1;
            vq_cyc.push_back(cyc);
            vq_dat.push_back(int'(bus16.dat_o));
            vq_busy.push_back(int'(bus16.busy_o));
        end
        if (bus16.timeout_o) begin
            t16_n   = t16_n + 1;
            t16_dat = int'(bus16.dat_o);
        end
        if (bus8.valid_o) begin
            v8_n   = v8_n + 1;
            v8_dat = int'(bus8.dat_o);
        end
        if (bus8.timeout_o) begin
            t8_n   = t8_n + 1;
            t8_dat = int'(bus8.dat_o);
            t8_cyc = cyc;
        end
    end

    int checks = 0;
    int errors = 0;
    int b_v16, b_t16, b_v8, b_t8;

    task automatic chk(input string name, input longint act, input longint exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic snap();
        b_v16 = v16_n;
        b_t16 = t16_n;
        b_v8  = v8_n;
        b_t8  = t8_n;
    endtask

    task automatic pulse_start(input bit sel8, output int s);
        @(negedge clk);
        if (sel8) bus8.start_i = 1'b1;
        else      bus16.start_i = 1'b1;
        s = cyc + 1;
        @(negedge clk);
        bus8.start_i  = 1'b0;
        bus16.start_i = 1'b0;
    endtask

    task automatic wait_events(input bit sel8, input int need, input int bound, input string name);
        int n;
        for (int k = 0; k < bound; k++) begin
            n = sel8 ? (v8_n - b_v8) + (t8_n - b_t8) : (v16_n - b_v16) + (t16_n - b_t16);
            if (n >= need) break;
            @(negedge clk);
        end
        n = sel8 ? (v8_n - b_v8) + (t8_n - b_t8) : (v16_n - b_v16) + (t16_n - b_t16);
        chk({"wait_", name}, longint'(n >= need), 1);
    endtask

    typedef struct {
        bit sel8;
        int per;
        bit exp_to;
        int exp_dat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int s;
        int s2;
        bus16.en_i = 1'b0; bus16.start_i = 1'b0; bus16.cont_i = 1'b0;
        bus8.en_i  = 1'b0; bus8.start_i  = 1'b0; bus8.cont_i  = 1'b0;

        // 16-bit: dat = 8 * period. 8-bit: 31*8=248 fits, 32*8=256 closes
        // exactly on saturation (valid, 255), 33 and no-ref time out.
        vecs[0] = '{1'b0, 100, 1'b0, 800};
        vecs[1] = '{1'b0,  37, 1'b0, 296};
        vecs[2] = '{1'b0,   2, 1'b0,  16};
        vecs[3] = '{1'b0, 250, 1'b0, 2000};
        vecs[4] = '{1'b1,  31, 1'b0, 248};
        vecs[5] = '{1'b1,  32, 1'b0, 255};
        vecs[6] = '{1'b1,  33, 1'b1, 255};
        vecs[7] = '{1'b1,   0, 1'b1, 255};

        repeat (3) @(negedge clk);
        chk("rst_busy16",    bus16.busy_o, 0);
        chk("rst_valid16",   bus16.valid_o, 0);
        chk("rst_timeout16", bus16.timeout_o, 0);
        chk("rst_dat16",     bus16.dat_o, 0);
        chk("rst_dat8",      bus8.dat_o, 0);
        rst_n = 1'b1;
        bus16.en_i = 1'b1;
        bus8.en_i  = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].sel8) per8 = vecs[i].per;
            else              per16 = vecs[i].per;
            repeat (2 * vecs[i].per + 10) @(negedge clk);
            snap();
            pulse_start(vecs[i].sel8, s);
            wait_events(vecs[i].sel8, 1, 3000, $sformatf("vec%0d", i));
            repeat (4) @(negedge clk);
            if (vecs[i].sel8) begin
                chk($sformatf("vec%0d_valid_n", i), v8_n - b_v8, vecs[i].exp_to ? 0 : 1);
                chk($sformatf("vec%0d_to_n", i),    t8_n - b_t8, vecs[i].exp_to ? 1 : 0);
                chk($sformatf("vec%0d_dat", i),     bus8.dat_o, vecs[i].exp_dat);
                chk($sformatf("vec%0d_busy", i),    bus8.busy_o, 0);
                if (vecs[i].per == 0)
                    chk("noref_to_cycle", t8_cyc, s + 256);
            end else begin
                chk($sformatf("vec%0d_valid_n", i), v16_n - b_v16, vecs[i].exp_to ? 0 : 1);
                chk($sformatf("vec%0d_to_n", i),    t16_n - b_t16, vecs[i].exp_to ? 1 : 0);
                chk($sformatf("vec%0d_dat", i),     bus16.dat_o, vecs[i].exp_dat);
                chk($sformatf("vec%0d_busy", i),    bus16.busy_o, 0);
            end
        end

        // Continuous mode: back-to-back 512-cycle windows, no gap period
        per16 = 64;
        repeat (140) @(negedge clk);
        snap();
        bus16.cont_i = 1'b1;
        pulse_start(1'b0, s);
        wait_events(1'b0, 4, 3000, "cont4");
        bus16.cont_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (b_v16 + k < vq_dat.size()) begin
                chk($sformatf("cont_dat%0d", k),  vq_dat[b_v16 + k], 512);
                chk($sformatf("cont_busy%0d", k), vq_busy[b_v16 + k], 1);
                if (k > 0)
                    chk($sformatf("cont_gap%0d", k), vq_cyc[b_v16 + k] - vq_cyc[b_v16 + k - 1], 512);
            end
        end
        wait_events(1'b0, 5, 700, "cont_last");
        repeat (4) @(negedge clk);
        chk("cont_valid_n", v16_n - b_v16, 5);
        chk("cont_to_n",    t16_n - b_t16, 0);
        chk("cont_busy_end", bus16.busy_o, 0);

        // Reference stops mid-measurement on the 8-bit instance
        per8 = 20;
        repeat (50) @(negedge clk);
        snap();
        pulse_start(1'b1, s);
        repeat (60) @(negedge clk);
        per8 = 0;
        wait_events(1'b1, 1, 700, "refstop");
        repeat (4) @(negedge clk);
        chk("refstop_to_n",    t8_n - b_t8, 1);
        chk("refstop_valid_n", v8_n - b_v8, 0);
        chk("refstop_dat",     t8_dat, 255);
        chk("refstop_busy",    bus8.busy_o, 0);

        // start_i while busy must not restart the window
        per16 = 100;
        repeat (210) @(negedge clk);
        snap();
        pulse_start(1'b0, s);
        repeat (300) @(negedge clk);
        pulse_start(1'b0, s2);
        wait_events(1'b0, 1, 2000, "busy_restart");
        repeat (4) @(negedge clk);
        chk("restart_valid_n", v16_n - b_v16, 1);
        chk("restart_to_n",    t16_n - b_t16, 0);
        chk("restart_dat",     bus16.dat_o, 800);
        if (v16_n > b_v16)
            chk("restart_timing", longint'(vq_cyc[b_v16] <= s + 903), 1);

        // Enable drop mid-measurement, then start_i ignored while disabled
        per16 = 50;
        repeat (110) @(negedge clk);
        snap();
        pulse_start(1'b0, s);
        repeat (100) @(negedge clk);
        chk("abort_busy_before", bus16.busy_o, 1);
        bus16.en_i = 1'b0;
        @(negedge clk);
        chk("abort_busy_after", bus16.busy_o, 0);
        pulse_start(1'b0, s);
        repeat (5) @(negedge clk);
        chk("abort_start_ignored", bus16.busy_o, 0);
        repeat (600) @(negedge clk);
        chk("abort_valid_n", v16_n - b_v16, 0);
        chk("abort_to_n",    t16_n - b_t16, 0);
        chk("abort_dat_kept", bus16.dat_o, 800);

        // Asynchronous reset mid-measurement clears outputs without a clock edge
        bus16.en_i = 1'b1;
        pulse_start(1'b0, s);
        repeat (100) @(negedge clk);
        chk("prereset_busy", bus16.busy_o, 1);
        rst_n = 1'b0;
        #1;
        chk("areset_busy16",  bus16.busy_o, 0);
        chk("areset_dat16",   bus16.dat_o, 0);
        chk("areset_valid16", bus16.valid_o, 0);
        chk("areset_dat8",    bus8.dat_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_busy", bus16.busy_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
